// File: rtl/cheshire_pkg.sv
// Shared Cheshire definitions used by the preload arbiter.
// Contents: preload arbiter FSM state type, preload requester index
// constants and the boot-mode value that enables preload grants.
package cheshire_pkg;

  typedef enum logic [1:0] {
    PreloadArbIdle    = 2'd0,
    PreloadArbBurst   = 2'd1,
    PreloadArbAbort   = 2'd2,
    PreloadArbWaitRsp = 2'd3
  } preload_arb_state_e;

  localparam int unsigned PreloadReqJtag  = 0;
  localparam int unsigned PreloadReqSlink = 1;
  localparam int unsigned PreloadReqUart  = 2;

  localparam logic [1:0] BootModeIdle = 2'd0;

endpackage

// File: rtl/cheshire_preload_rr_pick.sv
// Combinational round-robin picker for the preload arbiter.
// Searches i_valid starting at index i_ptr+1 (wrapping modulo NumReq)
// and returns the first set index.
// Ports:
//   i_valid  per-requester valid
//   i_ptr    most recent grantee; it gets the lowest priority
//   i_en     picker enable; o_found stays 0 when low
//   o_idx    chosen index (0 when nothing found)
//   o_found  a valid requester was found
module cheshire_preload_rr_pick #(
  parameter int unsigned NumReq = 3
) (
  input  logic [NumReq-1:0] i_valid,
  input  logic [1:0]        i_ptr,
  input  logic              i_en,
  output logic [1:0]        o_idx,
  output logic              o_found
);

  logic [2:0] w_sum;
  logic       w_hit;

  // i_ptr < NumReq and the offset is <= NumReq, so one conditional
  // subtraction is enough to wrap the candidate index.
  always_comb begin
    o_idx = '0;
    w_hit = 1'b0;
    w_sum = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      w_sum = {1'b0, i_ptr} + 3'(off);
      if (w_sum >= 3'(NumReq)) w_sum = w_sum - 3'(NumReq);
      if (i_en && !w_hit && i_valid[w_sum[1:0]]) begin
        w_hit = 1'b1;
        o_idx = w_sum[1:0];
      end
    end
    o_found = w_hit;
  end

endmodule

// File: rtl/cheshire_preload_arb.sv
// Shares the single preload write port into memory between the JTAG,
// Serial Link and UART preload requesters. Whole bursts are granted
// round-robin; the grant is held until the memory write response.
// Stalled bursts are closed with a zero-strobe abort beat and bursts
// longer than MaxBurst are cut short, so memory never hangs mid-burst.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   boot_mode_i              grants only while equal to BootModeIdle
//   req_*_i / req_ready_o    per-requester beat channel (flattened)
//   rsp_valid_o, rsp_err_o   burst response to the owning requester
//   mem_*_o / mem_ready_i    write beat channel towards memory
//   mem_rsp_valid_i/_err_i   burst write response from memory
//   busy_o, gnt_idx_o        not idle / current or last grantee
//   abort_cnt_o              saturating count of aborted bursts
module cheshire_preload_arb
  import cheshire_pkg::*;
#(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned MaxBurst      = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    boot_mode_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq*DataWidth/8-1:0] req_strb_i,
  input  logic [NumReq-1:0]             req_last_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [NumReq-1:0]             rsp_valid_o,
  output logic                          rsp_err_o,
  output logic                          mem_valid_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_data_o,
  output logic [DataWidth/8-1:0]        mem_strb_o,
  output logic                          mem_last_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_rsp_valid_i,
  input  logic                          mem_rsp_err_i,
  output logic                          busy_o,
  output logic [1:0]                    gnt_idx_o,
  output logic [7:0]                    abort_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned BeatW     = $clog2(MaxBurst) + 1;
  localparam int unsigned IdleW     = $clog2(TimeoutCycles) + 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(MaxBurst - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);

  preload_arb_state_e   r_state;
  logic [1:0]           r_ptr;
  logic [1:0]           r_gnt;
  logic                 r_err;
  logic [BeatW-1:0]     r_beat_cnt;
  logic [IdleW-1:0]     r_idle_cnt;
  logic [AddrWidth-1:0] r_last_addr;
  logic [7:0]           r_abort_cnt;

  logic                 w_pick_en;
  logic                 w_pick_found;
  logic [1:0]           w_pick_idx;
  logic                 w_g_valid;
  logic                 w_g_last;
  logic [AddrWidth-1:0] w_g_addr;
  logic [DataWidth-1:0] w_g_data;
  logic [StrbWidth-1:0] w_g_strb;
  logic [AddrWidth-1:0] w_pick_addr;
  logic                 w_force_last;
  logic                 w_mem_last;
  logic                 w_beat_acc;
  logic                 w_timeout;

  assign w_pick_en = (r_state == PreloadArbIdle) && (boot_mode_i == BootModeIdle);

  cheshire_preload_rr_pick #(
    .NumReq (NumReq)
  ) i_rr_pick (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .i_en    (w_pick_en),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_g_valid    = req_valid_i[r_gnt];
  assign w_g_last     = req_last_i[r_gnt];
  assign w_g_addr     = req_addr_i[r_gnt*AddrWidth +: AddrWidth];
  assign w_g_data     = req_data_i[r_gnt*DataWidth +: DataWidth];
  assign w_g_strb     = req_strb_i[r_gnt*StrbWidth +: StrbWidth];
  assign w_pick_addr  = req_addr_i[w_pick_idx*AddrWidth +: AddrWidth];
  assign w_force_last = (r_beat_cnt == BeatLast);
  assign w_mem_last   = w_g_last | w_force_last;
  assign w_beat_acc   = (r_state == PreloadArbBurst) & w_g_valid & mem_ready_i;
  // Timeout needs an idle cycle, so it can never coincide with an
  // accepted last beat; the last beat always wins.
  assign w_timeout    = !w_g_valid && (r_idle_cnt == IdleLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= PreloadArbIdle;
      r_ptr       <= 2'(NumReq - 1);
      r_gnt       <= '0;
      r_err       <= 1'b0;
      r_beat_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_last_addr <= '0;
      r_abort_cnt <= '0;
    end else begin
      case (r_state)
        PreloadArbIdle: begin
          if (w_pick_found) begin
            r_gnt       <= w_pick_idx;
            r_beat_cnt  <= '0;
            r_idle_cnt  <= '0;
            // An abort before any accepted beat targets the burst's first address.
            r_last_addr <= w_pick_addr;
            r_state     <= PreloadArbBurst;
          end
        end
        PreloadArbBurst: begin
          if (w_beat_acc) begin
            r_beat_cnt  <= r_beat_cnt + 1'b1;
            r_last_addr <= w_g_addr;
            if (w_force_last && !w_g_last) r_err <= 1'b1;
          end
          if (w_g_valid)       r_idle_cnt <= '0;
          else if (!w_timeout) r_idle_cnt <= r_idle_cnt + 1'b1;
          if (w_beat_acc && w_mem_last) r_state <= PreloadArbWaitRsp;
          else if (w_timeout)           r_state <= PreloadArbAbort;
        end
        PreloadArbAbort: begin
          if (mem_ready_i) begin
            r_err <= 1'b1;
            if (r_abort_cnt != '1) r_abort_cnt <= r_abort_cnt + 1'b1;
            r_state <= PreloadArbWaitRsp;
          end
        end
        PreloadArbWaitRsp: begin
          if (mem_rsp_valid_i) begin
            r_ptr   <= r_gnt;
            r_err   <= 1'b0;
            r_state <= PreloadArbIdle;
          end
        end
        default: r_state <= PreloadArbIdle;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_strb_o  = '0;
    mem_last_o  = 1'b0;
    case (r_state)
      PreloadArbBurst: begin
        mem_valid_o        = w_g_valid;
        mem_addr_o         = w_g_addr;
        mem_data_o         = w_g_data;
        mem_strb_o         = w_g_strb;
        mem_last_o         = w_mem_last;
        req_ready_o[r_gnt] = mem_ready_i;
      end
      PreloadArbAbort: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = r_last_addr;
        mem_last_o  = 1'b1;
      end
      PreloadArbWaitRsp: begin
        rsp_valid_o[r_gnt] = mem_rsp_valid_i;
        rsp_err_o          = mem_rsp_valid_i & (mem_rsp_err_i | r_err);
      end
      default: ;
    endcase
  end

  assign busy_o      = (r_state != PreloadArbIdle);
  assign gnt_idx_o   = r_gnt;
  assign abort_cnt_o = r_abort_cnt;

endmodule
